// File: rtl/stream_arbiter_qos_aging.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : stream_arbiter_qos_aging
// Description : Packet-level N:1 stream arbiter. Picks one input stream per
//               packet by {urgent, qos}, round-robin among equal keys. Per-stream
//               age counters make starved streams urgent. The output goes
//               through a one-entry register stage (AXI-Stream style hold).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               s_data_in         - STREAM_COUNT x T_DATA_WIDTH input data (flat)
//               s_qos_in          - STREAM_COUNT x T_QOS__WIDTH input QoS (flat)
//               s_last_in         - per-stream last beat flag
//               s_valid_in        - per-stream valid
//               s_ready_out       - per-stream ready (at most one bit set)
//               m_data_out, m_qos_out, m_id_out, m_last_out, m_valid_out
//                                 - registered output stream
//               m_ready_in        - downstream ready
// Revision    : 1.0 - initial release
// ============================================================================
module stream_arbiter_qos_aging #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 4,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
  parameter int AGE_WIDTH    = 4,
  parameter int AGE_LIMIT    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [STREAM_COUNT*T_DATA_WIDTH-1:0] s_data_in,
  input  logic [STREAM_COUNT*T_QOS__WIDTH-1:0] s_qos_in,
  input  logic [STREAM_COUNT-1:0]              s_last_in,
  input  logic [STREAM_COUNT-1:0]              s_valid_in,
  output logic [STREAM_COUNT-1:0]              s_ready_out,
  output logic [T_DATA_WIDTH-1:0]              m_data_out,
  output logic [T_QOS__WIDTH-1:0]              m_qos_out,
  output logic [T_ID___WIDTH-1:0]              m_id_out,
  output logic                                 m_last_out,
  output logic                                 m_valid_out,
  input  logic                                 m_ready_in
);

  localparam int                   KEY_W       = T_QOS__WIDTH + 1;
  localparam logic [AGE_WIDTH-1:0] c_age_limit = AGE_WIDTH'(AGE_LIMIT);
  localparam logic [0:0]           c_st_idle   = 1'b0;
  localparam logic [0:0]           c_st_busy   = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [T_ID___WIDTH-1:0] grant_id_q, grant_id_d;
  logic [T_QOS__WIDTH-1:0] grant_qos_q, grant_qos_d;
  logic [T_ID___WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [AGE_WIDTH-1:0]    age_q [STREAM_COUNT];
  logic [AGE_WIDTH-1:0]    age_d [STREAM_COUNT];
  logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [T_QOS__WIDTH-1:0] m_qos_q, m_qos_d;
  logic [T_ID___WIDTH-1:0] m_id_q, m_id_d;
  logic                    m_last_q, m_last_d;
  logic                    m_valid_q, m_valid_d;

  logic [STREAM_COUNT-1:0] w_urgent;
  logic [T_ID___WIDTH-1:0] w_arb_win;
  logic                    w_arb_fire;
  logic                    w_out_ready;
  logic                    w_accept;
  logic [T_DATA_WIDTH-1:0] w_beat_data;
  logic                    w_beat_last;

  // A stream is urgent once it has lost AGE_LIMIT arbitrations; a limit of 0
  // turns aging off entirely.
  generate
    for (genvar gi = 0; gi < STREAM_COUNT; gi++) begin : g_urgent
      assign w_urgent[gi] = (AGE_LIMIT != 0) && (age_q[gi] == c_age_limit);
    end
  endgenerate

  assign w_arb_fire  = (state_q == c_st_idle) && (|s_valid_in);
  assign w_out_ready = !m_valid_q || m_ready_in;
  assign w_accept    = (state_q == c_st_busy) && s_valid_in[grant_id_q] && w_out_ready;
  assign w_beat_data = s_data_in[grant_id_q*T_DATA_WIDTH +: T_DATA_WIDTH];
  assign w_beat_last = s_last_in[grant_id_q];

  // Scan from rr_ptr+1 with wrap; strict '>' keeps the first stream seen
  // among equal keys, which gives round-robin tie breaking.
  always_comb begin
    logic [KEY_W-1:0] best_key;
    logic [KEY_W-1:0] key;
    logic             found;
    int               idx;
    best_key  = '0;
    key       = '0;
    found     = 1'b0;
    idx       = 0;
    w_arb_win = '0;
    for (int off = 1; off <= STREAM_COUNT; off++) begin
      idx = (int'(rr_ptr_q) + off) % STREAM_COUNT;
      key = {w_urgent[idx], s_qos_in[idx*T_QOS__WIDTH +: T_QOS__WIDTH]};
      if (s_valid_in[idx] && (!found || (key > best_key))) begin
        found     = 1'b1;
        best_key  = key;
        w_arb_win = T_ID___WIDTH'(idx);
      end
    end
  end

  always_comb begin
    s_ready_out = '0;
    if (!rst && (state_q == c_st_busy)) begin
      s_ready_out[grant_id_q] = w_out_ready;
    end
  end

  // Ages move only on arbitration cycles; saturating at the limit means the
  // counter never wraps back to a non-urgent value.
  always_comb begin
    for (int i = 0; i < STREAM_COUNT; i++) begin
      age_d[i] = age_q[i];
      if (w_arb_fire) begin
        if (w_arb_win == T_ID___WIDTH'(i)) begin
          age_d[i] = '0;
        end else if (s_valid_in[i] && (age_q[i] != c_age_limit)) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    grant_qos_d = grant_qos_q;
    rr_ptr_d    = rr_ptr_q;
    if (w_arb_fire) begin
      state_d     = c_st_busy;
      grant_id_d  = w_arb_win;
      grant_qos_d = s_qos_in[w_arb_win*T_QOS__WIDTH +: T_QOS__WIDTH];
      rr_ptr_d    = w_arb_win;
    end else if (w_accept && w_beat_last) begin
      state_d = c_st_idle;
    end
  end

  // Load and drain may coincide, so a packet streams at one beat per cycle.
  always_comb begin
    m_data_d  = m_data_q;
    m_qos_d   = m_qos_q;
    m_id_d    = m_id_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    if (w_accept) begin
      m_data_d  = w_beat_data;
      m_qos_d   = grant_qos_q;
      m_id_d    = grant_id_q;
      m_last_d  = w_beat_last;
      m_valid_d = 1'b1;
    end else if (m_ready_in) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_st_idle;
      grant_id_q  <= '0;
      grant_qos_q <= '0;
      rr_ptr_q    <= T_ID___WIDTH'(STREAM_COUNT - 1);
      for (int i = 0; i < STREAM_COUNT; i++) age_q[i] <= '0;
      m_data_q    <= '0;
      m_qos_q     <= '0;
      m_id_q      <= '0;
      m_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      grant_qos_q <= grant_qos_d;
      rr_ptr_q    <= rr_ptr_d;
      for (int i = 0; i < STREAM_COUNT; i++) age_q[i] <= age_d[i];
      m_data_q    <= m_data_d;
      m_qos_q     <= m_qos_d;
      m_id_q      <= m_id_d;
      m_last_q    <= m_last_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign m_data_out  = m_data_q;
  assign m_qos_out   = m_qos_q;
  assign m_id_out    = m_id_q;
  assign m_last_out  = m_last_q;
  assign m_valid_out = m_valid_q;

endmodule
`default_nettype wire
